// File: rtl/arb_request_buffer.sv
`default_nettype none
//==============================================================================
// arb_request_buffer : per-lane flit FIFOs raising requests toward a matrix
// arbiter; optional packet lock enabled by ARB_PACKET_LOCK_EN.   Rev 1.0
//==============================================================================
`ifndef CHANNELS
`define CHANNELS 5
`endif

module arb_request_buffer #(
   parameter int CHANNELS = `CHANNELS,
   parameter int FLIT_W   = 32,
   parameter int DEPTH    = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [CHANNELS-1:0]        in_valid,
   input  logic [CHANNELS*FLIT_W-1:0] in_data,
   input  logic [CHANNELS-1:0]        in_tail,
   output logic [CHANNELS-1:0]        in_ready,
   input  logic                       out_ready,
   output logic [CHANNELS-1:0]        request_vector,
   input  logic [CHANNELS-1:0]        grant_vector,
   output logic                       out_valid,
   output logic [FLIT_W-1:0]          out_data,
   output logic                       out_tail,
   output logic                       grant_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [CHANNELS-1:0] not_empty;
   logic [CHANNELS-1:0] lock_mask;
   logic [CHANNELS-1:0] pop;
   logic [FLIT_W:0]     head [CHANNELS];
   logic                onehot;
   logic                legal;

   assign request_vector = not_empty & lock_mask & {CHANNELS{out_ready}};

   // A grant is honoured only if it is empty or a single bit on a requesting lane
   assign onehot = (grant_vector != '0) &&
                   ((grant_vector & (grant_vector - CHANNELS'(1))) == '0);
   assign legal  = (grant_vector == '0) ||
                   (onehot && ((grant_vector & ~request_vector) == '0));
   assign pop       = legal ? grant_vector : '0;
   assign out_valid = |pop;

   always_comb begin
      {out_tail, out_data} = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (pop[i]) {out_tail, out_data} = head[i];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) grant_err <= 1'b0;
      else     grant_err <= ~legal;
   end

`ifdef ARB_PACKET_LOCK_EN
   localparam int LANE_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic              lock_active;
   logic [LANE_W-1:0] lock_lane;
   logic [LANE_W-1:0] pop_lane;

   always_comb begin
      pop_lane = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (pop[i]) pop_lane = LANE_W'(i);
      end
   end

   assign lock_mask = lock_active ? (CHANNELS'(1) << lock_lane) : '1;

   // Only the locked lane can pop while locked, so its tail releases the lock
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lock_active <= 1'b0;
         lock_lane   <= '0;
      end else if (out_valid) begin
         if (!lock_active && !out_tail) begin
            lock_active <= 1'b1;
            lock_lane   <= pop_lane;
         end else if (lock_active && out_tail) begin
            lock_active <= 1'b0;
         end
      end
   end
`else
   assign lock_mask = '1;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [CNT_W-1:0] count;
      logic [FLIT_W:0]  mem [DEPTH];
      logic             push;

      assign in_ready[i]  = (count != FULL);
      assign not_empty[i] = (count != '0);
      assign push         = in_valid[i] & in_ready[i];
      assign head[i]      = mem[rd_ptr];

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop[i]) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop[i])      count <= count + CNT_W'(1);
            else if (!push && pop[i]) count <= count - CNT_W'(1);
         end
      end

      // Storage is not reset: a slot is only read after it has been written
      always_ff @(posedge CLK) begin
         if (push) mem[wr_ptr] <= {in_tail[i], in_data[i*FLIT_W +: FLIT_W]};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_arb_request_buffer.sv
`default_nettype none
//==============================================================================
// tb_arb_request_buffer : directed bench with a queue-based reference model
//==============================================================================
module tb_arb_request_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic [4:0]   in_valid;
   logic [159:0] in_data;
   logic [4:0]   in_tail;
   logic [4:0]   in_ready;
   logic         out_ready;
   logic [4:0]   request_vector;
   logic [4:0]   grant_vector;
   logic         out_valid;
   logic [31:0]  out_data;
   logic         out_tail;
   logic         grant_err;

   int checks = 0;
   int errors = 0;

   arb_request_buffer #(.CHANNELS(5), .FLIT_W(32), .DEPTH(4)) dut (
      .CLK(clk), .RST(rst),
      .in_valid(in_valid), .in_data(in_data), .in_tail(in_tail), .in_ready(in_ready),
      .out_ready(out_ready), .request_vector(request_vector), .grant_vector(grant_vector),
      .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail), .grant_err(grant_err)
   );

   always #5 clk = ~clk;

   // Reference model: one queue of {tail,data} per lane
   logic [32:0] mq [5][$];
   logic        m_err = 1'b0;
   logic        m_lock = 1'b0;
   int          m_lock_lane = 0;

   function automatic void eval(output logic [4:0] req, output int lane);
      logic [4:0] mask;
      logic       legal;
      mask = m_lock ? (5'b00001 << m_lock_lane) : 5'b11111;
      req  = '0;
      for (int i = 0; i < 5; i++) req[i] = (mq[i].size() != 0) && out_ready && mask[i];
      legal = (grant_vector == 5'b0) ||
              (($countones(grant_vector) == 1) && ((grant_vector & ~req) == 5'b0));
      lane = -1;
      if (legal) for (int i = 0; i < 5; i++) if (grant_vector[i]) lane = i;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) mq[i].delete();
         m_err  = 1'b0;
         m_lock = 1'b0;
      end else begin
         logic [4:0]  req;
         int          lane;
         int          sz [5];
         logic [32:0] f;
         for (int i = 0; i < 5; i++) sz[i] = mq[i].size();
         eval(req, lane);
         m_err = (grant_vector != 5'b0) && (lane < 0);
         if (lane >= 0) begin
            f = mq[lane].pop_front();
`ifdef ARB_PACKET_LOCK_EN
            if (!m_lock && !f[32]) begin
               m_lock = 1'b1;
               m_lock_lane = lane;
            end else if (m_lock && f[32]) begin
               m_lock = 1'b0;
            end
`endif
         end
         for (int i = 0; i < 5; i++)
            if (in_valid[i] && sz[i] != 4) mq[i].push_back({in_tail[i], in_data[i*32 +: 32]});
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic [4:0]  req;
      int          lane;
      logic [4:0]  rdy;
      logic [32:0] hd;
      eval(req, lane);
      for (int i = 0; i < 5; i++) rdy[i] = (mq[i].size() != 4);
      hd = '0;
      if (lane >= 0) hd = mq[lane][0];
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("request_vector", 64'(request_vector), 64'(req));
      check("out_valid", 64'(out_valid), 64'(lane >= 0));
      check("out_data", 64'(out_data), 64'(hd[31:0]));
      check("out_tail", 64'(out_tail), 64'(hd[32]));
      check("grant_err", 64'(grant_err), 64'(m_err));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic push1(input int lane, input logic [31:0] d, input logic t);
      in_valid = '0;
      in_valid[lane] = 1'b1;
      in_data[lane*32 +: 32] = d;
      in_tail[lane] = t;
      tick();
      in_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = '0; in_data = '0; in_tail = '0;
      out_ready = 1'b1; grant_vector = '0;
      repeat (2) tick();
      settle();
      check("lit_reset_in_ready", 64'(in_ready), 64'h1F);
      check("lit_reset_request", 64'(request_vector), 64'h0);
      check("lit_reset_out_valid", 64'(out_valid), 64'h0);
      check("lit_reset_grant_err", 64'(grant_err), 64'h0);
      rst = 1'b0;
      tick();

      // Single flit through lane 2
      in_valid = 5'b00100; in_data[64 +: 32] = 32'hA5A5A5A5; in_tail[2] = 1'b1;
      settle();
      check("lit_no_bypass", 64'(request_vector), 64'h0);
      tick();
      in_valid = '0; grant_vector = 5'b00100;
      settle();
      check("lit_lane2_request", 64'(request_vector), 64'h04);
      check("lit_lane2_valid", 64'(out_valid), 64'h1);
      check("lit_lane2_data", 64'(out_data), 64'hA5A5A5A5);
      tick();
      grant_vector = '0;
      settle();
      check("lit_lane2_drained", 64'(request_vector), 64'h0);
      tick();

      // Fill lane 0, then pop at full and stream push+pop across the wrap
      for (int k = 0; k < 4; k++) push1(0, 32'h100 + k, k == 3);
      settle();
      check("lit_lane0_full", 64'(in_ready[0]), 64'h0);
      tick();
      grant_vector = 5'b00001;
      settle();
      check("lit_first_pop", 64'(out_data), 64'h100);
      tick();
      grant_vector = '0;
      settle();
      check("lit_ready_again", 64'(in_ready[0]), 64'h1);
      tick();
      for (int k = 0; k < 4; k++) begin
         in_valid = 5'b00001; in_data[31:0] = 32'h104 + k; in_tail[0] = 1'b0;
         grant_vector = 5'b00001;
         settle();
         if (k == 3) check("lit_wrap_order", 64'(out_data), 64'h104);
         tick();
      end
      in_valid = '0;
      for (int k = 0; k < 3; k++) begin
         settle();
         if (k == 2) check("lit_drain_last", 64'(out_data), 64'h107);
         tick();
      end
      grant_vector = '0;
      tick();

      // Illegal grants: multi-hot, then a grant to an idle lane
      in_valid = 5'b00011; in_data[31:0] = 32'h200; in_data[63:32] = 32'h201; in_tail[1:0] = 2'b11;
      tick();
      in_valid = '0; grant_vector = 5'b00011;
      settle();
      check("lit_multihot_no_pop", 64'(out_valid), 64'h0);
      tick();
      grant_vector = '0;
      settle();
      check("lit_err_set", 64'(grant_err), 64'h1);
      check("lit_err_counts_kept", 64'(request_vector), 64'h03);
      tick();
      settle();
      check("lit_err_one_cycle", 64'(grant_err), 64'h0);
      tick();
      grant_vector = 5'b00100;
      tick();
      grant_vector = '0;
      settle();
      check("lit_err_idle_lane", 64'(grant_err), 64'h1);
      tick();
      grant_vector = 5'b00001;
      tick();
      grant_vector = 5'b00010;
      settle();
      check("lit_lane1_after_err", 64'(out_data), 64'h201);
      tick();
      grant_vector = '0;

      // Back-pressure gates requests combinationally
      out_ready = 1'b0;
      in_valid = 5'b01010; in_data[63:32] = 32'h301; in_data[127:96] = 32'h303; in_tail = 5'b11111;
      tick();
      in_valid = '0;
      settle();
      check("lit_stalled_request", 64'(request_vector), 64'h0);
      tick();
      out_ready = 1'b1;
      settle();
      check("lit_released_request", 64'(request_vector), 64'h0A);
      tick();
      grant_vector = 5'b01000;
      settle();
      check("lit_lane3_data", 64'(out_data), 64'h303);
      tick();
      grant_vector = 5'b00010;
      tick();
      grant_vector = '0;

      // Multi-flit packet on lane 1 competing with lane 4
      push1(1, 32'h401, 1'b0);
      push1(1, 32'h402, 1'b0);
      push1(1, 32'h403, 1'b1);
      push1(4, 32'h404, 1'b1);
      settle();
      check("lit_both_request", 64'(request_vector), 64'h12);
      tick();
      grant_vector = 5'b00010;
      tick();
      grant_vector = '0;
      settle();
`ifdef ARB_PACKET_LOCK_EN
      check("lit_locked_request", 64'(request_vector), 64'h02);
`else
      check("lit_unlocked_request", 64'(request_vector), 64'h12);
`endif
      tick();
      grant_vector = 5'b00010;
      tick();
      settle();
      check("lit_tail_flit", 64'(out_tail), 64'h1);
      tick();
      grant_vector = '0;
      settle();
      check("lit_lane4_requests", 64'(request_vector), 64'h10);
      tick();
      grant_vector = 5'b10000;
      tick();
      grant_vector = '0;

      // Asynchronous reset with lanes partially full
      push1(0, 32'h501, 1'b0);
      push1(0, 32'h502, 1'b1);
      push1(2, 32'h503, 1'b1);
      rst = 1'b1;
      #1;
      check("lit_async_in_ready", 64'(in_ready), 64'h1F);
      check("lit_async_request", 64'(request_vector), 64'h0);
      tick();
      rst = 1'b0;
      settle();
      check("lit_post_reset_request", 64'(request_vector), 64'h0);
      tick();
      push1(0, 32'h601, 1'b1);
      grant_vector = 5'b00001;
      settle();
      check("lit_fresh_data_only", 64'(out_data), 64'h601);
      tick();
      grant_vector = '0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
